// File: rtl/nvdla_nocif_arb_cfg_reg.sv
// ---------------------------------------------------------------------------
// nvdla_nocif_arb_cfg_reg
//
// CSB-style configuration register block for the NOCIF read/write arbiters.
// Holds the outstanding-request limits and per-client arbitration weights.
//
// Build option:
//   NVDLA_NOCIF_CFG_SHADOW_EN  defined   -> register writes land in a staging
//                                            copy; a CTRL commit copies staging
//                                            to the active outputs on the first
//                                            edge where the arbiter is idle.
//                              undefined -> register writes update the active
//                                            outputs directly.
//
// Ports:
//   nvdla_core_clk   clock
//   nvdla_core_rst   synchronous reset, active-high
//   req_pvld/prdy    CSB request handshake; req_write, req_addr, req_wdat
//   rsp_pvld/prdy    response handshake; rsp_rdat (0 for writes), rsp_err
//   idle             arbiter idle, gates commits
//   rd_os_cnt        active read outstanding limit
//   wr_os_cnt        active write outstanding limit
//   rd_weight        active read weights, client i at [8i+7:8i]
//   wr_weight        active write weights, client i at [8i+7:8i]
//   cfg_update       one-cycle pulse when the active set changes
//
// Register map (byte offsets):
//   0x000 OS_CNT     [7:0] rd, [15:8] wr
//   0x004 CTRL       wr: bit0 commit, bit1 clear err; rd: {err, commit_pending}
//   0x008 STATUS     rd-only: {err, commit_pending, idle}
//   0x010 + 4k       RD_WEIGHT_k, four clients per register
//   0x090 + 4k       WR_WEIGHT_k, four clients per register
// ---------------------------------------------------------------------------
module nvdla_nocif_arb_cfg_reg #(
  parameter int RD_CLIENTS = 12,
  parameter int WR_CLIENTS = 8
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic                    req_pvld,
  output logic                    req_prdy,
  input  logic                    req_write,
  input  logic [11:0]             req_addr,
  input  logic [31:0]             req_wdat,
  output logic                    rsp_pvld,
  input  logic                    rsp_prdy,
  output logic [31:0]             rsp_rdat,
  output logic                    rsp_err,
  input  logic                    idle,
  output logic [7:0]              rd_os_cnt,
  output logic [7:0]              wr_os_cnt,
  output logic [8*RD_CLIENTS-1:0] rd_weight,
  output logic [8*WR_CLIENTS-1:0] wr_weight,
  output logic                    cfg_update
);

  localparam int RD_REGS = (RD_CLIENTS + 3) / 4;
  localparam int WR_REGS = (WR_CLIENTS + 3) / 4;

  localparam logic [11:0] ADDR_OS     = 12'h000;
  localparam logic [11:0] ADDR_CTRL   = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h008;
  localparam logic [11:0] ADDR_RD_W   = 12'h010;
  localparam logic [11:0] ADDR_WR_W   = 12'h090;

  logic [7:0]              stg_rd_os;
  logic [7:0]              stg_wr_os;
  logic [8*RD_CLIENTS-1:0] stg_rd_weight;
  logic [8*WR_CLIENTS-1:0] stg_wr_weight;
  logic                    err;
  logic                    commit_pending;

  // -------------------------------------------------------------------------
  // Address decode. Weight windows are matched by offset so that slots past
  // the client count, and unaligned offsets, fall out as unmapped.
  // -------------------------------------------------------------------------
  logic [11:0] rd_off;
  logic [11:0] wr_off;
  logic [2:0]  rd_idx;
  logic [2:0]  wr_idx;
  logic        hit_os, hit_ctrl, hit_status, hit_rd_w, hit_wr_w;
  logic        hit_stage;
  logic        acc_err;
  logic        req_acc;

  assign rd_off     = req_addr - ADDR_RD_W;
  assign wr_off     = req_addr - ADDR_WR_W;
  assign rd_idx     = rd_off[4:2];
  assign wr_idx     = wr_off[4:2];
  assign hit_os     = (req_addr == ADDR_OS);
  assign hit_ctrl   = (req_addr == ADDR_CTRL);
  assign hit_status = (req_addr == ADDR_STATUS);
  assign hit_rd_w   = (rd_off[11:5] == '0) && (rd_off[1:0] == '0) &&
                      ({1'b0, rd_idx} < 4'(RD_REGS));
  assign hit_wr_w   = (wr_off[11:5] == '0) && (wr_off[1:0] == '0) &&
                      ({1'b0, wr_idx} < 4'(WR_REGS));
  assign hit_stage  = hit_os | hit_rd_w | hit_wr_w;

  // STATUS is the only mapped register that rejects writes.
  assign acc_err = req_write ? !(hit_stage | hit_ctrl)
                             : !(hit_stage | hit_ctrl | hit_status);

  // One-deep response stage: a new request fits when the slot is empty or
  // draining this cycle. No path from req_pvld.
  assign req_prdy = !rsp_pvld || rsp_prdy;
  assign req_acc  = req_pvld && req_prdy;

  // -------------------------------------------------------------------------
  // Read data mux
  // -------------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin
    // NOTE: every branch below is optional, so the default keeps this block
    // purely combinational instead of holding the previous value in a latch.
    rd_data = '0;
    if (hit_os) begin
      rd_data = {16'b0, stg_wr_os, stg_rd_os};
    end else if (hit_ctrl) begin
      rd_data = {30'b0, err, commit_pending};
    end else if (hit_status) begin
      rd_data = {29'b0, err, commit_pending, idle};
    end else if (hit_rd_w) begin
      for (int c = 0; c < RD_CLIENTS; c++) begin
        if (rd_idx == 3'(c / 4)) rd_data[8*(c%4) +: 8] = stg_rd_weight[8*c +: 8];
      end
    end else if (hit_wr_w) begin
      for (int c = 0; c < WR_CLIENTS; c++) begin
        if (wr_idx == 3'(c / 4)) rd_data[8*(c%4) +: 8] = stg_wr_weight[8*c +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Staging registers. Lanes without a client have no storage, so writes to
  // them vanish and reads return zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: the weight arrays are ordinary flops that the arbiter consumes
    // straight away, so they are reset like any control state rather than
    // treated as uninitialised storage.
    if (nvdla_core_rst) begin
      stg_rd_os     <= 8'hFF;
      stg_wr_os     <= 8'hFF;
      stg_rd_weight <= {RD_CLIENTS{8'h01}};
      stg_wr_weight <= {WR_CLIENTS{8'h01}};
    end else if (req_acc && req_write) begin
      if (hit_os) begin
        stg_rd_os <= req_wdat[7:0];
        stg_wr_os <= req_wdat[15:8];
      end
      for (int c = 0; c < RD_CLIENTS; c++) begin
        if (hit_rd_w && rd_idx == 3'(c / 4))
          stg_rd_weight[8*c +: 8] <= req_wdat[8*(c%4) +: 8];
      end
      for (int c = 0; c < WR_CLIENTS; c++) begin
        if (hit_wr_w && wr_idx == 3'(c / 4))
          stg_wr_weight[8*c +: 8] <= req_wdat[8*(c%4) +: 8];
      end
    end
  end

`ifdef NVDLA_NOCIF_CFG_SHADOW_EN
  logic commit_fire;

  assign commit_fire = commit_pending && idle;

  // A commit request arriving on the copy edge is absorbed by the copy.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      commit_pending <= 1'b0;
    end else if (commit_fire) begin
      commit_pending <= 1'b0;
    end else if (req_acc && req_write && hit_ctrl && req_wdat[0]) begin
      commit_pending <= 1'b1;
    end
  end

  // The copy samples staging before any write accepted on the same edge.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rd_os_cnt  <= 8'hFF;
      wr_os_cnt  <= 8'hFF;
      rd_weight  <= {RD_CLIENTS{8'h01}};
      wr_weight  <= {WR_CLIENTS{8'h01}};
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= commit_fire;
      if (commit_fire) begin
        rd_os_cnt <= stg_rd_os;
        wr_os_cnt <= stg_wr_os;
        rd_weight <= stg_rd_weight;
        wr_weight <= stg_wr_weight;
      end
    end
  end
`else
  // Staging is the active set; idle only feeds the STATUS readback.
  assign commit_pending = 1'b0;
  assign rd_os_cnt      = stg_rd_os;
  assign wr_os_cnt      = stg_wr_os;
  assign rd_weight      = stg_rd_weight;
  assign wr_weight      = stg_wr_weight;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) cfg_update <= 1'b0;
    else                cfg_update <= req_acc && req_write && hit_stage;
  end
`endif

  // -------------------------------------------------------------------------
  // Sticky error flag and response stage
  // -------------------------------------------------------------------------
  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop regardless of block order.
    if (nvdla_core_rst) begin
      err <= 1'b0;
    end else if (req_acc && acc_err) begin
      err <= 1'b1;
    end else if (req_acc && req_write && hit_ctrl && req_wdat[1]) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rsp_pvld <= 1'b0;
      rsp_rdat <= '0;
      rsp_err  <= 1'b0;
    end else if (req_acc) begin
      rsp_pvld <= 1'b1;
      rsp_rdat <= req_write ? 32'h0 : rd_data;
      rsp_err  <= acc_err;
    end else if (rsp_prdy) begin
      rsp_pvld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nvdla_nocif_arb_cfg_reg.sv
module tb_nvdla_nocif_arb_cfg_reg;

  localparam int RD = 5;
  localparam int WR = 6;
  localparam int RD_REGS = (RD + 3) / 4;
  localparam int WR_REGS = (WR + 3) / 4;
`ifdef NVDLA_NOCIF_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          nvdla_core_clk = 1'b0;
  logic          nvdla_core_rst = 1'b1;
  logic          req_pvld = 1'b0;
  logic          req_prdy;
  logic          req_write = 1'b0;
  logic [11:0]   req_addr = '0;
  logic [31:0]   req_wdat = '0;
  logic          rsp_pvld;
  logic          rsp_prdy = 1'b1;
  logic [31:0]   rsp_rdat;
  logic          rsp_err;
  logic          idle = 1'b1;
  logic [7:0]    rd_os_cnt;
  logic [7:0]    wr_os_cnt;
  logic [8*RD-1:0] rd_weight;
  logic [8*WR-1:0] wr_weight;
  logic          cfg_update;

  nvdla_nocif_arb_cfg_reg #(.RD_CLIENTS(RD), .WR_CLIENTS(WR)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .req_pvld       (req_pvld),
    .req_prdy       (req_prdy),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdat       (req_wdat),
    .rsp_pvld       (rsp_pvld),
    .rsp_prdy       (rsp_prdy),
    .rsp_rdat       (rsp_rdat),
    .rsp_err        (rsp_err),
    .idle           (idle),
    .rd_os_cnt      (rd_os_cnt),
    .wr_os_cnt      (wr_os_cnt),
    .rd_weight      (rd_weight),
    .wr_weight      (wr_weight),
    .cfg_update     (cfg_update)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: byte-per-client arrays, staging and active copies.
  // ---------------------------------------------------------------------
  typedef struct { logic [31:0] rdat; logic err; } rsp_t;
  rsp_t exp_q[$];

  byte unsigned s_rd_w[RD], s_wr_w[WR], a_rd_w[RD], a_wr_w[WR];
  byte unsigned s_rd_os, s_wr_os, a_rd_os, a_wr_os;
  bit m_pend, m_err, m_cfg;
  bit chk_en = 1'b0;

  // kind: 0 OS, 1 CTRL, 2 STATUS, 3 RD weight, 4 WR weight, -1 unmapped
  function automatic int decode(input int addr, output int idx);
    idx = 0;
    if (addr == 0) return 0;
    if (addr == 4) return 1;
    if (addr == 8) return 2;
    if (addr % 4 != 0) return -1;
    if (addr >= 'h10 && (addr - 'h10) / 4 < RD_REGS) begin idx = (addr - 'h10) / 4; return 3; end
    if (addr >= 'h90 && (addr - 'h90) / 4 < WR_REGS) begin idx = (addr - 'h90) / 4; return 4; end
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input int kind, input int idx);
    logic [31:0] v = '0;
    case (kind)
      0: v = {16'b0, s_wr_os, s_rd_os};
      1: v = {30'b0, m_err, m_pend};
      2: v = {29'b0, m_err, m_pend, idle};
      3: for (int j = 0; j < 4; j++) if (4*idx + j < RD) v[8*j +: 8] = s_rd_w[4*idx + j];
      4: for (int j = 0; j < 4; j++) if (4*idx + j < WR) v[8*j +: 8] = s_wr_w[4*idx + j];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] pack_rd();
    logic [63:0] v = '0;
    for (int c = 0; c < RD; c++) v[8*c +: 8] = a_rd_w[c];
    return v;
  endfunction

  function automatic logic [63:0] pack_wr();
    logic [63:0] v = '0;
    for (int c = 0; c < WR; c++) v[8*c +: 8] = a_wr_w[c];
    return v;
  endfunction

  // Model / scoreboard push: compares the active outputs for the current
  // cycle, then predicts what the next clock edge will do.
  always @(negedge nvdla_core_clk) begin
    if (chk_en) begin
      check("rd_os_cnt", rd_os_cnt, a_rd_os);
      check("wr_os_cnt", wr_os_cnt, a_wr_os);
      check("rd_weight", rd_weight, pack_rd());
      check("wr_weight", wr_weight, pack_wr());
      check("cfg_update", cfg_update, m_cfg);
    end
    if (nvdla_core_rst) begin
      s_rd_os = 8'hFF; s_wr_os = 8'hFF; a_rd_os = 8'hFF; a_wr_os = 8'hFF;
      foreach (s_rd_w[c]) begin s_rd_w[c] = 1; a_rd_w[c] = 1; end
      foreach (s_wr_w[c]) begin s_wr_w[c] = 1; a_wr_w[c] = 1; end
      m_pend = 0; m_err = 0; m_cfg = 0;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      bit commit;
      bit acc;
      commit = SHADOW && m_pend && idle;
      acc    = req_pvld && req_prdy;
      m_cfg  = commit;
      if (acc) begin
        int idx, kind;
        bit e;
        rsp_t r;
        kind = decode(int'(req_addr), idx);
        e = (kind < 0) || (req_write && kind == 2);
        r.rdat = (req_write || e) ? 32'h0 : model_read(kind, idx);
        r.err  = e;
        exp_q.push_back(r);
        if (commit) begin
          a_rd_os = s_rd_os; a_wr_os = s_wr_os; a_rd_w = s_rd_w; a_wr_w = s_wr_w;
        end
        if (req_write) begin
          if (kind == 0) begin s_rd_os = req_wdat[7:0]; s_wr_os = req_wdat[15:8]; end
          for (int j = 0; j < 4; j++) begin
            if (kind == 3 && 4*idx + j < RD) s_rd_w[4*idx + j] = req_wdat[8*j +: 8];
            if (kind == 4 && 4*idx + j < WR) s_wr_w[4*idx + j] = req_wdat[8*j +: 8];
          end
          if (!SHADOW && (kind == 0 || kind == 3 || kind == 4)) begin
            a_rd_os = s_rd_os; a_wr_os = s_wr_os; a_rd_w = s_rd_w; a_wr_w = s_wr_w;
            m_cfg = 1'b1;
          end
        end
        if (commit) m_pend = 0;
        else if (SHADOW && req_write && kind == 1 && req_wdat[0]) m_pend = 1;
        if (e) m_err = 1;
        else if (req_write && kind == 1 && req_wdat[1]) m_err = 0;
      end else if (commit) begin
        a_rd_os = s_rd_os; a_wr_os = s_wr_os; a_rd_w = s_rd_w; a_wr_w = s_wr_w;
        m_pend = 0;
      end
    end
  end

  // Monitor: compares whatever response the DUT presents against the head
  // of the scoreboard; the head is retired on a completed handshake.
  always @(negedge nvdla_core_clk) begin
    if (chk_en && !nvdla_core_rst && rsp_pvld) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        check("rsp_rdat", rsp_rdat, exp_q[0].rdat);
        check("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_prdy) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  bit rand_prdy = 1'b0;

  always @(posedge nvdla_core_clk) begin
    #1;
    if (rand_prdy) rsp_prdy = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge nvdla_core_clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input bit w, input logic [11:0] a, input logic [31:0] d);
    int  n = 0;
    bit  done = 0;
    req_pvld = 1'b1; req_write = w; req_addr = a; req_wdat = d;
    while (!done) begin
      @(negedge nvdla_core_clk);
      if (req_prdy) done = 1;
      else if (++n > 200) begin
        check("send_timeout", 1, 0);
        done = 1;
      end
      @(posedge nvdla_core_clk);
      #1;
    end
    req_pvld = 1'b0;
  endtask

  logic [11:0] addr_pool[13];

  initial begin
    addr_pool = '{12'h000, 12'h004, 12'h008, 12'h010, 12'h014, 12'h018, 12'h090,
                  12'h094, 12'h098, 12'h00C, 12'h002, 12'hFFC, 12'h0AC};

    tick(3);
    nvdla_core_rst = 1'b0;
    @(negedge nvdla_core_clk);
    check("reset_rd_os", rd_os_cnt, 8'hFF);
    check("reset_req_prdy", req_prdy, 1);
    check("reset_rsp_pvld", rsp_pvld, 0);
    tick(1);

    // Reset values read back
    send(0, 12'h000, 0);
    send(0, 12'h010, 0);
    send(0, 12'h090, 0);

    // Staged weight write held off by a busy arbiter, then committed
    idle = 1'b0;
    send(1, 12'h010, 32'h04030201);
    send(1, 12'h004, 32'h1);
    send(0, 12'h008, 0);
    tick(3);
    idle = 1'b1;
    tick(2);
    send(0, 12'h008, 0);

    // Partially populated weight register, slot beyond client count, err clear
    send(1, 12'h014, 32'hFFFFFFFF);
    send(0, 12'h014, 0);
    send(1, 12'h018, 32'h12345678);
    send(0, 12'h008, 0);
    send(1, 12'h004, 32'h2);
    send(0, 12'h008, 0);

    // Back-pressure: a second read waits until the response drains
    tick(2);
    rsp_prdy = 1'b0;
    req_pvld = 1'b1; req_write = 1'b0; req_addr = 12'h000;
    tick(1);
    req_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      @(negedge nvdla_core_clk);
      check("req_prdy_held", req_prdy, 0);
      tick(1);
    end
    rsp_prdy = 1'b1;
    @(negedge nvdla_core_clk);
    check("req_prdy_release", req_prdy, 1);
    tick(1);
    req_pvld = 1'b0;
    tick(2);

    // Staging write on the same edge as a commit copy
    idle = 1'b0;
    send(1, 12'h004, 32'h1);
    idle = 1'b1;
    send(1, 12'h000, 32'h1020);
    send(1, 12'h004, 32'h1);
    tick(3);
    @(negedge nvdla_core_clk);
    check("os_rd_after_commit", rd_os_cnt, 8'h20);
    check("os_wr_after_commit", wr_os_cnt, 8'h10);
    tick(1);

    // Reset with a commit pending and a response stalled
    idle = 1'b0;
    send(1, 12'h004, 32'h1);
    tick(1);
    rsp_prdy = 1'b0;
    send(0, 12'h000, 0);
    nvdla_core_rst = 1'b1;
    tick(1);
    nvdla_core_rst = 1'b0;
    @(negedge nvdla_core_clk);
    check("rst_mid_rsp_pvld", rsp_pvld, 0);
    check("rst_mid_req_prdy", req_prdy, 1);
    check("rst_mid_wr_os", wr_os_cnt, 8'hFF);
    tick(1);
    rsp_prdy = 1'b1;
    send(0, 12'h008, 0);
    send(0, 12'h000, 0);

    // Randomised traffic
    rand_prdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        nvdla_core_rst = 1'b1;
        tick(1);
        nvdla_core_rst = 1'b0;
      end
      idle = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) tick(1);
      send($urandom_range(0, 1) != 0, addr_pool[$urandom_range(0, 12)], $urandom);
    end
    rand_prdy = 1'b0;
    tick(1);
    rsp_prdy = 1'b1;
    tick(5);
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
